bcd_to_bin_seq: RTL
===================

// Module: bcd_to_bin_seq
// PURPOSE
//  Sequential BCD-to-binary converter, the inverse of the BCD display-digit path.
//  Takes NDIG packed BCD digits (e.g. stopwatch/preset entry) and produces the binary count value.
//  One digit per clock: acc <= acc*10 + digit, MS digit first. start/busy/done handshake.
// PARAMETERS
//  NDIG   4   number of BCD digits in bcd_in
//  BIN_W  14  binary result width; must be >= ceil(log2(10^NDIG)) (14 for NDIG=4)
// PORTS
//  clk      in   1        system clock, rising edge; the block's only clock
//  reset    in   1        asynchronous, active-low reset
//  start    in   1        request conversion; accepted only when busy==0
//  bcd_in   in   4*NDIG   packed digits; [3:0]=ones, [7:4]=tens, ... MS digit at top
//  busy     out  1        conversion in progress; start ignored while high
//  done     out  1        one-cycle pulse: bin_out/err valid and updated
//  bin_out  out  BIN_W    binary result; holds last result until next done
//  err      out  1        >=1 digit >9 in last conversion; updated with done
// BEHAVIOUR
//  Reset (reset==0, async): state=IDLE; busy=0, done=0, bin_out=0, err=0; acc, digit index, capture reg cleared.
//  States: IDLE -> CONV -> DONE -> IDLE.
//  IDLE/DONE: start==1 at rising edge -> capture bcd_in, acc=0, idx=NDIG-1, err_acc=0, go CONV, busy=1.
//  CONV: per edge acc <= acc*10 + digit[idx] (acc*10 = (acc<<3)+(acc<<1), computed in BIN_W+4 bits, truncated to BIN_W); idx decrements.
//   After processing idx==0 -> DONE; same edge loads bin_out, err; busy=0.
//  DONE: done=1 for exactly one cycle; next edge -> IDLE, or -> CONV if start==1 (back-to-back).
//  Latency: done high after NDIG+1 edges, counting the accepting edge (5 for NDIG=4); throughput 1 per NDIG+1 cycles.
//  bcd_in sampled only on the accepting edge; later changes have no effect.
//  start while busy==1: ignored, not queued.
//  bin_out/err change only on the edge entering DONE; otherwise hold.
//  Reset mid-conversion: abort immediately to reset values; no done pulse for the aborted request.
//  Overflow: cannot occur when BIN_W meets the rule above; otherwise result is modulo 2^BIN_W with no flag.
// CONFIGURATION
//  Macro BCD2BIN_DIGIT_CHECK_EN:
//   defined: any captured digit >9 sets err; that conversion returns bin_out=0, err=1, same latency.
//   undefined: no digit check; err tied 0; digits 10..15 enter the arithmetic as their raw binary value.
// STRUCTURE
//  bcd_pkg: BCD_DIGIT_W=4, BCD_MAX_DIGIT=9, state enum {S_IDLE,S_CONV,S_DONE}, width helper for BIN_W.
//  Sub-module bcd_mac10 (combinational): acc*10 + digit, with the >9 digit flag; instantiated once.
//  Top holds FSM, digit capture register, down-counter idx, acc and output registers.
// TESTING
//  1. Reset then start with bcd_in=16'h9999 -> done after 5 edges; bin_out=9999 (14'h270F), err=0, busy high for 4 cycles.
//  2. bcd_in=16'h1234 -> bin_out=1234 (0x04D2); then 16'h0000 -> bin_out=0, done pulse exactly 1 cycle.
//  3. Start accepted, bcd_in changed to 16'h5555 and start pulsed during CONV -> result from the first value; single done pulse.
//  4. start held high across DONE -> back-to-back conversions, done every 5 cycles, each with the correct value.
//  5. bcd_in=16'h12A4 with BCD2BIN_DIGIT_CHECK_EN -> bin_out=0, err=1. Without the macro -> bin_out=1304, err=0.
//  6. reset=0 asserted in the 2nd CONV cycle -> outputs 0 immediately, no done. After release, 16'h0042 -> bin_out=42.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared constants, state encoding and width helper for the BCD-to-binary converter.
package bcd_pkg;

  localparam int unsigned BCD_DIGIT_W = 4;
  localparam logic [BCD_DIGIT_W-1:0] BCD_MAX_DIGIT = 4'd9;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Smallest binary width that holds every value of an ndig-digit decimal number.
  function automatic int unsigned bin_w_for(input int unsigned ndig);
    longint unsigned pow10;
    pow10 = 1;
    for (int unsigned i = 0; i < ndig; i++) pow10 = pow10 * 10;
    return $clog2(pow10);
  endfunction

endpackage

// File: rtl/bcd_mac10.sv
// Combinational multiply-by-ten-and-add step with an out-of-range digit flag.
module bcd_mac10
  import bcd_pkg::*;
#(
  parameter int unsigned BIN_W    = 14,
  parameter bit          CHECK_EN = 1'b0
) (
  input  logic [BIN_W-1:0]       acc,
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic [BIN_W-1:0]       acc_next,
  output logic                   digit_bad
);

  // acc*10 built from shifts in a widened domain, then truncated back to BIN_W
  assign acc_next = BIN_W'(({4'b0000, acc} << 3) + ({4'b0000, acc} << 1)
                           + (BIN_W + 4)'(digit));

  assign digit_bad = CHECK_EN && (digit > BCD_MAX_DIGIT);

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter: one digit per clock, MS digit first.
// Optional macro BCD2BIN_DIGIT_CHECK_EN enables the digit>9 error check.
module bcd_to_bin_seq
  import bcd_pkg::*;
#(
  parameter int unsigned NDIG  = 4,
  parameter int unsigned BIN_W = bin_w_for(NDIG)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [BCD_DIGIT_W*NDIG-1:0] bcd_in,
  output logic                        busy,
  output logic                        done,
  output logic [BIN_W-1:0]            bin_out,
  output logic                        err
);

`ifdef BCD2BIN_DIGIT_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  localparam int unsigned IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  state_t                        state;
  logic [BCD_DIGIT_W*NDIG-1:0]   cap;
  logic [IDX_W-1:0]              idx;
  logic [BIN_W-1:0]              acc;
  logic                          err_acc;
  logic [BCD_DIGIT_W-1:0]        digit;
  logic [BIN_W-1:0]              acc_next;
  logic                          digit_bad;
  logic                          err_any;

  // Select the digit currently being folded into the accumulator
  always_comb begin
    digit = cap[idx*BCD_DIGIT_W +: BCD_DIGIT_W];
  end

  assign err_any = err_acc | digit_bad;

  bcd_mac10 #(
    .BIN_W    (BIN_W),
    .CHECK_EN (CHECK_EN)
  ) u_mac10 (
    .acc       (acc),
    .digit     (digit),
    .acc_next  (acc_next),
    .digit_bad (digit_bad)
  );

  // Control FSM, datapath registers and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      bin_out <= '0;
      err     <= 1'b0;
      acc     <= '0;
      idx     <= '0;
      cap     <= '0;
      err_acc <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            cap     <= bcd_in;
            acc     <= '0;
            idx     <= IDX_W'(NDIG - 1);
            err_acc <= 1'b0;
            busy    <= 1'b1;
            state   <= S_CONV;
          end else begin
            state <= S_IDLE;
          end
        end
        S_CONV: begin
          acc     <= acc_next;
          err_acc <= err_any;
          if (idx == '0) begin
            state   <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            bin_out <= err_any ? '0 : acc_next;
            err     <= err_any;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
